// File: rtl/obstacle_collision_detector.sv
// Decodes the multiplexed obstacle/dino LED drive buses into per-window frame
// bitmaps and latches game_over after HIT_FRAMES consecutive armed overlaps.
module obstacle_collision_detector #(
  parameter int WINDOW      = 50000,
  parameter int HIT_FRAMES  = 2,
  parameter int ARM_WINDOWS = 4
) (
  input  logic         clk,
  input  logic         flag_restart,
  input  logic [7:0]   ob_row,
  input  logic [15:0]  ob_col,
  input  logic [7:0]   dino_row,
  input  logic [15:0]  dino_col,
  output logic         frame_valid,
  output logic [127:0] frame_obs,
  output logic [127:0] frame_dino,
  output logic [7:0]   overlap_cnt,
  output logic         hit,
  output logic         game_over
);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);
  localparam logic [3:0] ARM_N = 4'(ARM_WINDOWS);
  localparam logic [3:0] HIT_N = 4'(HIT_FRAMES);

  localparam logic [1:0] ST_ARMING  = 2'd0;
  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam logic [1:0] ST_OVER    = 2'd2;

  logic [127:0] pix_obs, pix_dino;
  logic [127:0] acc_obs_q, acc_dino_q;
  logic [127:0] frame_obs_q, frame_dino_q;
  logic [WW-1:0] wcnt_q;
  logic         frame_valid_q, hit_q, hit_d;
  logic [7:0]   overlap_q, overlap_d;
  logic [3:0]   armcnt_q, run_q, run_d;
  logic [1:0]   state_q, state_d;
  logic         wend, armed;

  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 16; c++) begin : g_col
      assign pix_obs[r*16+c]  = ob_row[r]   & ~ob_col[c];
      assign pix_dino[r*16+c] = dino_row[r] & ~dino_col[c];
    end
  end

  function automatic logic [7:0] popcnt(input logic [127:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 128; i++) n = n + 8'(v[i]);
    return n;
  endfunction

  assign wend  = (wcnt_q == WLAST);
  assign armed = (armcnt_q == ARM_N);

  // Evaluation runs on the cycle frame_valid is high, using the fresh snapshot.
  always_comb begin
    overlap_d = popcnt(frame_obs_q & frame_dino_q);
    run_d     = run_q;
    state_d   = state_q;
    hit_d     = 1'b0;
    if (state_q == ST_ARMING && armed) state_d = ST_PLAYING;
    if (!armed) begin
      run_d = '0;
    end else if (frame_valid_q && state_q != ST_OVER) begin
      if (overlap_d != 8'd0) run_d = (run_q == 4'hf) ? run_q : run_q + 4'd1;
      else                   run_d = '0;
      if (run_d == HIT_N) begin
        hit_d   = 1'b1;
        state_d = ST_OVER;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flag_restart) begin
      wcnt_q        <= '0;
      acc_obs_q     <= '0;
      acc_dino_q    <= '0;
      frame_obs_q   <= '0;
      frame_dino_q  <= '0;
      frame_valid_q <= 1'b0;
      overlap_q     <= '0;
      armcnt_q      <= '0;
      run_q         <= '0;
      hit_q         <= 1'b0;
      state_q       <= ST_ARMING;
    end else begin
      frame_valid_q <= wend;
      if (wend) begin
        wcnt_q       <= '0;
        frame_obs_q  <= acc_obs_q | pix_obs;
        frame_dino_q <= acc_dino_q | pix_dino;
        acc_obs_q    <= '0;
        acc_dino_q   <= '0;
      end else begin
        wcnt_q     <= wcnt_q + WW'(1);
        acc_obs_q  <= acc_obs_q | pix_obs;
        acc_dino_q <= acc_dino_q | pix_dino;
      end
      if (frame_valid_q) begin
        overlap_q <= overlap_d;
        if (!armed) armcnt_q <= armcnt_q + 4'd1;
      end
      run_q   <= run_d;
      hit_q   <= hit_d;
      state_q <= state_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_obs   = frame_obs_q;
  assign frame_dino  = frame_dino_q;
  assign overlap_cnt = overlap_q;
  assign hit         = hit_q;
  assign game_over   = (state_q == ST_OVER);
endmodule

// File: tb/tb_obstacle_collision_detector.sv
// Scoreboard bench: the driver models each window and queues expected
// snapshots/evaluations; a negedge monitor pops and compares them.
module tb_obstacle_collision_detector;
  localparam int W = 16, HF = 2, AW = 1;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic         flag_restart;
  logic [7:0]   ob_row, dino_row;
  logic [15:0]  ob_col, dino_col;
  logic         frame_valid, hit, game_over;
  logic [127:0] frame_obs, frame_dino;
  logic [7:0]   overlap_cnt;

  obstacle_collision_detector #(.WINDOW(W), .HIT_FRAMES(HF), .ARM_WINDOWS(AW)) dut (
    .clk(gclk), .flag_restart(flag_restart),
    .ob_row(ob_row), .ob_col(ob_col), .dino_row(dino_row), .dino_col(dino_col),
    .frame_valid(frame_valid), .frame_obs(frame_obs), .frame_dino(frame_dino),
    .overlap_cnt(overlap_cnt), .hit(hit), .game_over(game_over)
  );

  typedef struct { logic [127:0] obs; logic [127:0] dino; int cyc; } frm_t;
  typedef struct { logic [7:0] ov; logic hit; logic go; } evl_t;
  frm_t frmq[$];
  evl_t evq[$];

  int nchk = 0, nerr = 0, cyc = 0;
  bit mon_en = 1'b0;
  always @(posedge gclk) cyc <= cyc + 1;

  // reference model state
  int mcnt = 0, marm = 0, mrun = 0;
  logic mover = 1'b0, meval = 1'b0;
  logic [127:0] macc_o = '0, macc_d = '0, mf_o = '0, mf_d = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] dec(input logic [7:0] row, input logic [15:0] col);
    logic [127:0] p;
    p = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) p[r*16+c] = row[r] & ~col[c];
    return p;
  endfunction

  task automatic drive(input logic [7:0] orow, input logic [15:0] ocol,
                       input logic [7:0] drow, input logic [15:0] dcol, input logic rst);
    evl_t e;
    frm_t f;
    int ov;
    ob_row = orow; ob_col = ocol; dino_row = drow; dino_col = dcol; flag_restart = rst;
    if (meval) begin
      meval = 1'b0;
      if (rst) e = '{8'd0, 1'b0, 1'b0};
      else begin
        ov = $countones(mf_o & mf_d);
        e.hit = 1'b0;
        if (marm != AW) mrun = 0;
        else if (!mover) begin
          mrun = (ov > 0) ? ((mrun < 15) ? mrun + 1 : 15) : 0;
          if (mrun == HF) begin e.hit = 1'b1; mover = 1'b1; end
        end
        if (marm < AW) marm++;
        e.ov = 8'(ov);
        e.go = mover;
      end
      evq.push_back(e);
    end
    if (rst) begin
      mcnt = 0; macc_o = '0; macc_d = '0; marm = 0; mrun = 0; mover = 1'b0;
    end else if (mcnt == W - 1) begin
      mf_o = macc_o | dec(orow, ocol);
      mf_d = macc_d | dec(drow, dcol);
      f.obs = mf_o; f.dino = mf_d; f.cyc = cyc + 1;
      frmq.push_back(f);
      macc_o = '0; macc_d = '0; mcnt = 0; meval = 1'b1;
    end else begin
      macc_o |= dec(orow, ocol);
      macc_d |= dec(drow, dcol);
      mcnt++;
    end
  endtask

  task automatic pat(input int kind, input int i, output logic [7:0] orow, output logic [15:0] ocol,
                     output logic [7:0] drow, output logic [15:0] dcol);
    logic [7:0] mr;
    logic [15:0] mc;
    mr = (i % 2 == 0) ? 8'h08 : 8'h03;
    mc = (i % 2 == 0) ? ~16'h0030 : ~16'h0100;
    orow = 8'h00; ocol = 16'hffff; drow = 8'h00; dcol = 16'hffff;
    case (kind)
      1: if (i == 5) begin orow = 8'h03; ocol = ~16'h0010; end
      2: begin orow = mr; ocol = mc; drow = 8'h08; dcol = ~16'h0010; end
      3: begin orow = mr; ocol = mc; end
      4: begin orow = mr; ocol = mc; drow = mr; dcol = mc; end
      5: if (i == 15) begin orow = 8'h04; ocol = ~16'h0001; end
      6: if (i == 0) begin orow = 8'h80; ocol = ~16'h8000; drow = 8'h80; dcol = ~16'h8000; end
      7: if (i == 15) begin orow = 8'h80; ocol = ~16'h8000; drow = 8'h80; dcol = ~16'h8000; end
      default: ;
    endcase
  endtask

  task automatic cycles(input int kind, input int n, input bit crst);
    logic [7:0] orow, drow;
    logic [15:0] ocol, dcol;
    for (int i = 0; i < n; i++) begin
      @(posedge gclk); #1;
      if (crst && i == 0) begin
        chk("rst_fv", frame_valid, 0);
        chk("rst_fobs", frame_obs, 0);
        chk("rst_fdino", frame_dino, 0);
        chk("rst_ov", overlap_cnt, 0);
        chk("rst_hit", hit, 0);
        chk("rst_go", game_over, 0);
      end
      pat(kind, i, orow, ocol, drow, dcol);
      drive(orow, ocol, drow, dcol, 1'b0);
    end
  endtask

  task automatic do_rst(input int n);
    repeat (n) begin
      @(posedge gclk); #1;
      drive(8'h00, 16'hffff, 8'h00, 16'hffff, 1'b1);
    end
  endtask

  initial begin : monitor
    frm_t f;
    evl_t e;
    bit evpend;
    evpend = 1'b0;
    forever begin
      @(negedge gclk);
      if (mon_en) begin
        if (evpend) begin
          evpend = 1'b0;
          if (evq.size() == 0) chk("eval_missing", 1, 0);
          else begin
            e = evq.pop_front();
            chk("overlap_cnt", overlap_cnt, e.ov);
            chk("hit", hit, e.hit);
            chk("game_over", game_over, e.go);
          end
        end else chk("hit_spurious", hit, 0);
        if (frame_valid === 1'b1) begin
          if (frmq.size() == 0) chk("fv_spurious", frame_valid, 0);
          else begin
            f = frmq.pop_front();
            chk("fv_cycle", cyc, f.cyc);
            chk("frame_obs", frame_obs, f.obs);
            chk("frame_dino", frame_dino, f.dino);
            evpend = 1'b1;
          end
        end else if (frmq.size() > 0 && frmq[0].cyc < cyc) begin
          chk("fv_missing", frame_valid, 1);
          void'(frmq.pop_front());
        end
      end
    end
  end

  initial begin
    flag_restart = 1'b1;
    ob_row = 8'h00; ob_col = 16'hffff; dino_row = 8'h00; dino_col = 16'hffff;
    // reset, decode, multiplexed overlap, sticky OVER, restart mid-window
    do_rst(3);
    mon_en = 1'b1;
    cycles(1, W, 1'b1);
    cycles(2, W, 1'b0);
    cycles(2, W, 1'b0);
    cycles(2, W, 1'b0);
    cycles(4, W, 1'b0);
    cycles(0, 5, 1'b0);
    do_rst(1);
    // grace period and broken run
    cycles(2, W, 1'b1);
    cycles(3, W, 1'b0);
    cycles(2, W, 1'b0);
    cycles(3, W, 1'b0);
    cycles(2, W, 1'b0);
    cycles(2, W, 1'b0);
    cycles(0, W, 1'b0);
    cycles(0, 3, 1'b0);
    do_rst(2);
    // boundary samples, then restart on the evaluation cycle
    cycles(5, W, 1'b1);
    cycles(6, W, 1'b0);
    cycles(7, W, 1'b0);
    do_rst(1);
    cycles(0, W, 1'b1);
    cycles(0, 4, 1'b0);
    chk("queues_drained", frmq.size() + evq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
